// File: rtl/seq_det_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Brief    : Serial pattern detector with window-limited runs, overlap
//            selection and per-run match counting.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int WIN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               start,
    input  logic               abort,
    input  logic               data,
    input  logic               data_valid,
    output logic               flag,
    output logic               busy,
    output logic               done,
    output logic [WIN_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_MAX_LEN = 4'(MAX_LEN);

    state_t             state_q,     state_d;
    logic [MAX_LEN-1:0] pat_q,       pat_d;
    logic [3:0]         len_q,       len_d;
    logic               ovl_q,       ovl_d;
    logic [WIN_W-1:0]   win_q,       win_d;
    logic [MAX_LEN-1:0] hist_q,      hist_d;
    logic [WIN_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [3:0]         fill_q,      fill_d;
    logic [WIN_W-1:0]   match_cnt_q, match_cnt_d;
    logic               flag_q,      flag_d;

    logic [MAX_LEN-1:0] w_hist_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic [3:0]         w_fill_inc;
    logic               w_match;

    // Match evaluation is based on the history as it will look after this bit.
    always_comb begin
        w_mask       = '0;
        w_hist_shift = {hist_q[MAX_LEN-2:0], data};
        w_fill_inc   = (fill_q == C_MAX_LEN) ? fill_q : fill_q + 4'd1;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (4'(i) < len_q);
        end
        w_match = (w_fill_inc >= len_q) &&
                  ((w_hist_shift & w_mask) == (pat_q & w_mask));
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        ovl_d       = ovl_q;
        win_d       = win_q;
        hist_d      = hist_q;
        bit_cnt_d   = bit_cnt_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        flag_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A config write wins over a simultaneous start.
                if (cfg_valid) begin
                    pat_d = cfg_pattern;
                    ovl_d = cfg_overlap;
                    win_d = cfg_window;
                    if (cfg_len == 4'd0)
                        len_d = 4'd1;
                    else if (cfg_len > C_MAX_LEN)
                        len_d = C_MAX_LEN;
                    else
                        len_d = cfg_len;
                end else if (start) begin
                    match_cnt_d = '0;
                    bit_cnt_d   = '0;
                    hist_d      = '0;
                    fill_d      = '0;
                    state_d     = (win_q == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (data_valid) begin
                    hist_d    = w_hist_shift;
                    bit_cnt_d = bit_cnt_q + WIN_W'(1);
                    fill_d    = w_fill_inc;
                    if (w_match) begin
                        flag_d      = 1'b1;
                        match_cnt_d = match_cnt_q + WIN_W'(1);
                        if (!ovl_q)
                            fill_d = 4'd0;
                    end
                    if (bit_cnt_d == win_q)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= 4'd1;
            ovl_q       <= 1'b0;
            win_q       <= '0;
            hist_q      <= '0;
            bit_cnt_q   <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            win_q       <= win_d;
            hist_q      <= hist_d;
            bit_cnt_q   <= bit_cnt_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            flag_q      <= flag_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign flag      = flag_q;
    assign match_cnt = match_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Brief    : Directed and randomized checks of seq_det_ctrl against a
//            queue-based reference model of the detection rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_window = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       data = 1'b0;
    logic       data_valid = 1'b0;
    logic       flag;
    logic       busy;
    logic       done;
    logic [7:0] match_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=idle, 1=running, 2=end-of-window cycle
    int       m_phase = 0;
    bit [7:0] m_pat   = '0;
    int       m_len   = 1;
    bit       m_ovl   = 1'b0;
    int       m_win   = 0;
    bit       m_bits[$];
    int       m_avail = 0;
    int       m_cnt   = 0;
    bit       m_flag  = 1'b0;

    seq_det_ctrl #(.MAX_LEN(8), .WIN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_window (cfg_window),
        .start      (start),
        .abort      (abort),
        .data       (data),
        .data_valid (data_valid),
        .flag       (flag),
        .busy       (busy),
        .done       (done),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit cv, input bit [7:0] cp, input bit [3:0] cl,
                         input bit co, input bit [7:0] cw, input bit st, input bit ab,
                         input bit d, input bit dv);
        bit hit;
        int n;
        m_flag = 1'b0;
        if (r) begin
            m_phase = 0; m_pat = '0; m_len = 1; m_ovl = 1'b0; m_win = 0;
            m_bits.delete(); m_avail = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            if (cv) begin
                m_pat = cp; m_ovl = co; m_win = cw;
                m_len = (cl == 0) ? 1 : (cl > 8) ? 8 : int'(cl);
            end else if (st) begin
                m_cnt = 0; m_bits.delete(); m_avail = 0;
                m_phase = (m_win == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (ab) begin
                m_phase = 0;
            end else if (dv) begin
                m_bits.push_back(d);
                m_avail++;
                n = m_bits.size();
                hit = (m_avail >= m_len);
                for (int i = 0; i < m_len; i++)
                    if (hit && m_bits[n-1-i] != m_pat[i]) hit = 1'b0;
                if (hit) begin
                    m_flag = 1'b1;
                    m_cnt++;
                    if (!m_ovl) m_avail = 0;
                end
                if (n == m_win) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit cv, input bit [7:0] cp, input bit [3:0] cl,
                       input bit co, input bit [7:0] cw, input bit st, input bit ab,
                       input bit d, input bit dv);
        @(negedge clk);
        rst = r; cfg_valid = cv; cfg_pattern = cp; cfg_len = cl; cfg_overlap = co;
        cfg_window = cw; start = st; abort = ab; data = d; data_valid = dv;
        @(posedge clk);
        model(r, cv, cp, cl, co, cw, st, ab, d, dv);
        #1;
        chk("flag",      32'(flag),      32'(m_flag));
        chk("done",      32'(done),      32'(m_phase == 2));
        chk("busy",      32'(busy),      32'(m_phase == 1));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_phase == 0));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt[7:0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input bit [7:0] p, input bit [3:0] l, input bit o, input bit [7:0] w);
        cyc(0, 1, p, l, o, w, 0, 0, 0, 0);
    endtask

    task automatic go();
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic bitin(input bit d, input bit dv, input bit ab);
        cyc(0, 0, 0, 0, 0, 0, 0, ab, d, dv);
    endtask

    initial begin
        bit [6:0] stream;
        stream = 7'b1011011;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Non-overlap: one match after bit 4
        cfg(8'b1011, 4, 0, 7);
        go();
        for (int i = 6; i >= 0; i--) bitin(stream[i], 1, 0);
        chk("nonovl_count", 32'(match_cnt), 32'd1);
        idle(2);

        // Overlap: matches after bit 4 and bit 7
        cfg(8'b1011, 4, 1, 7);
        go();
        for (int i = 6; i >= 0; i--) bitin(stream[i], 1, 0);
        chk("ovl_count", 32'(match_cnt), 32'd2);
        idle(2);

        // Valid gaps with toggled data on invalid cycles
        cfg(8'b1011, 4, 0, 7);
        go();
        for (int i = 6; i >= 0; i--) begin
            bitin(stream[i], 1, 0);
            if (i != 0) bitin(~stream[i], 0, 0);
        end
        idle(3);

        // Abort on the cycle bit 4 is sampled
        cfg(8'b1011, 4, 1, 7);
        go();
        for (int i = 6; i >= 4; i--) bitin(stream[i], 1, 0);
        bitin(stream[3], 1, 1);
        chk("abort_count", 32'(match_cnt), 32'd0);
        idle(2);

        // Config beats start; length 0 clamps to 1
        cyc(0, 1, 8'h01, 4'd0, 0, 8'd3, 1, 0, 0, 0);
        go();
        for (int i = 0; i < 3; i++) bitin(1, 1, 0);
        idle(2);
        chk("clamp_count", 32'(match_cnt), 32'd3);

        // Reset mid-run clears config: next start sees window 0
        cfg(8'b1011, 4, 0, 7);
        go();
        bitin(1, 1, 0);
        bitin(0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go();
        idle(2);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            int w;
            w = $urandom_range(0, 24);
            cfg(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'(w));
            go();
            for (int k = 0; k < w + 6; k++) begin
                cyc(1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 9) == 0), 8'($urandom), 4'($urandom),
                    1'($urandom), 8'($urandom_range(0, 12)),
                    1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 59) == 0),
                    1'($urandom), 1'($urandom_range(0, 9) < 7));
            end
            idle(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits.
REQ-002 The block SHALL have parameter WIN_W, default 8, giving the width of the window and match-count fields.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit: a configuration word is offered.
REQ-006 The block SHALL have port cfg_ready, output, 1 bit: a configuration word can be accepted.
REQ-007 The block SHALL have port cfg_pattern, input, MAX_LEN bits: the pattern, with bit [len-1] as the earliest bit.
REQ-008 The block SHALL have port cfg_len, input, 4 bits: the pattern length.
REQ-009 The block SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping.
REQ-010 The block SHALL have port cfg_window, input, WIN_W bits: the number of valid bits to inspect per run.
REQ-011 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a run.
REQ-012 The block SHALL have port abort, input, 1 bit: cancels a run in progress.
REQ-013 The block SHALL have port data, input, 1 bit: the serial data bit.
REQ-014 The block SHALL have port data_valid, input, 1 bit: data is meaningful this cycle.
REQ-015 The block SHALL have port flag, output, 1 bit: a one-cycle match pulse.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in the RUN state.
REQ-017 The block SHALL have port done, output, 1 bit: a one-cycle end-of-window pulse.
REQ-018 The block SHALL have port match_cnt, output, WIN_W bits: the number of matches in the current or last run.

Function
REQ-019 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-020 cfg_ready SHALL be 1 only in IDLE, and a config word SHALL be captured on cycles where cfg_valid and cfg_ready are both high.
REQ-021 A captured cfg_len of 0 SHALL be stored as 1, and a cfg_len greater than MAX_LEN SHALL be stored as MAX_LEN.
REQ-022 If cfg_valid, cfg_ready and start are all high in the same IDLE cycle, the config SHALL be captured and start ignored.
REQ-023 start in IDLE SHALL move the block to RUN and, on that edge, clear match_cnt, the bit counter, the history shift register and the fill counter; start outside IDLE SHALL be ignored.
REQ-024 start with a stored window of 0 SHALL go IDLE->DONE directly, with match_cnt = 0.
REQ-025 In RUN, each data_valid cycle SHALL shift data into the history register (newest bit at [0]), increment the bit counter, and increment the fill counter (saturating at MAX_LEN); cycles without data_valid SHALL change nothing.
REQ-026 A match SHALL occur on a valid bit when the fill counter after the shift is at least len and history[len-1:0] after the shift equals cfg_pattern[len-1:0].
REQ-027 flag SHALL pulse high for exactly one cycle, on the cycle after the matching bit is sampled, which is a latency of 1.
REQ-028 Each match SHALL increment match_cnt; no saturation logic is required, since match_cnt cannot exceed the window.
REQ-029 In non-overlap mode, a match SHALL reset the fill counter to 0, so no bit contributes to two matches; in overlap mode the fill counter SHALL be unaffected.
REQ-030 When the bit counter reaches the stored window on a valid bit, that bit SHALL still be evaluated and the block SHALL move to DONE.
REQ-031 DONE SHALL last exactly one cycle with done = 1, and the next state SHALL be IDLE.
REQ-032 abort in RUN SHALL return the block to IDLE on the next edge with no done pulse and match_cnt held; a match evaluated on the aborting cycle SHALL be discarded.
REQ-033 abort in IDLE or DONE SHALL have no effect.
REQ-034 match_cnt SHALL hold its value from the end of a run until the next start.
REQ-035 The stored configuration SHALL persist across runs until it is rewritten.

Reset
REQ-036 rst SHALL take effect on the clock edge only and SHALL override all other inputs, including during RUN.
REQ-037 After reset the block SHALL be in IDLE with flag = 0, done = 0, busy = 0, cfg_ready = 1 and match_cnt = 0.
REQ-038 After reset the stored configuration SHALL be pattern = 0, len = 1, overlap = 0 and window = 0, and the history register and all counters SHALL be 0.
REQ-039 Reset asserted mid-run SHALL drop busy on the next edge without pulsing flag or done.

Verification
REQ-040 Non-overlap case: config pattern 4'b1011, len 4, overlap 0, window 7; start; stream 1,0,1,1,0,1,1 on consecutive cycles -> flag one cycle after bit 4 only; done after bit 7; match_cnt = 1.
REQ-041 Overlap case: same stream with overlap 1 -> flag after bit 4 and after bit 7; match_cnt = 2.
REQ-042 Valid gaps: the non-overlap stream with data_valid low on alternate cycles (data toggled on the invalid cycles) -> same result as REQ-040, with flag and done delayed accordingly.
REQ-043 Abort: abort on the cycle bit 4 of the overlap stream is sampled -> no flag, no done, IDLE next cycle, match_cnt = 0.
REQ-044 Priority and length clamping: cfg_valid and start high together in IDLE -> config captured and state stays IDLE; cfg_len 0 with pattern LSB 1, window 3, stream 1,1,1 -> three flags, match_cnt = 3.
REQ-045 Reset: rst high during RUN after bit 2 -> next cycle busy = 0, match_cnt = 0, stored config cleared to reset values.
